// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port integer register file.
package reg_file_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_state_t;

  function automatic int depth(input int addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback side bus of the register file: two write ports, NUM_RD read ports.
interface reg_file_mp_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2
);
  logic                         init_done;
  logic                         we0;
  logic [ADDR_WIDTH-1:0]        w_addr0;
  logic [WIDTH-1:0]             w_data0;
  logic                         we1;
  logic [ADDR_WIDTH-1:0]        w_addr1;
  logic [WIDTH-1:0]             w_data1;
  logic [NUM_RD-1:0]            r_en;
  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_RD*WIDTH-1:0]      r_data;

  modport master (
    input  init_done, r_data,
    output we0, w_addr0, w_data0, we1, w_addr1, w_data1, r_en, r_addr
  );

  modport slave (
    output init_done, r_data,
    input  we0, w_addr0, w_data0, we1, w_addr1, w_data1, r_en, r_addr
  );
endinterface

// File: rtl/reg_file_mp_rd.sv
// One registered read port with write-first bypass from both write ports.
module rf_read_port #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic [WIDTH-1:0]      mem_q,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] w_addr0,
  input  logic [WIDTH-1:0]      w_data0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] w_addr1,
  input  logic [WIDTH-1:0]      w_data1,
  output logic [WIDTH-1:0]      r_data
);

  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] r_data_r;

  // Value the addressed register holds after this edge; x0 beats bypass, port 1 beats port 0.
  always_comb begin
    next_s = mem_q;
    if ((ZERO_REG != 0) && (r_addr == '0)) begin
      next_s = '0;
    end else if (we1 && (w_addr1 == r_addr)) begin
      next_s = w_data1;
    end else if (we0 && (w_addr0 == r_addr)) begin
      next_s = w_data0;
    end else begin
      next_s = mem_q;
    end
  end

  // Output register: zero while clearing, hold when not enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_r <= '0;
    end else if (!run) begin
      r_data_r <= '0;
    end else if (r_en) begin
      r_data_r <= next_s;
    end
  end

  assign r_data = r_data_r;

endmodule

// File: rtl/reg_file_mp.sv
// RV32 integer register file: clear-on-reset sequencer, two write ports, NUM_RD bypassed read ports.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = depth(ADDR_WIDTH);
  localparam int CW    = ADDR_WIDTH + 1;

  rf_state_t        state_r, state_nxt_s;
  logic [CW-1:0]    clr_cnt_r, clr_cnt_nxt_s;
  logic             init_done_r, init_done_nxt_s;
  logic             run_s;
  logic             wr0_s, wr1_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_s [NUM_RD];

  assign run_s         = (state_r == RUN);
  assign bus.init_done = init_done_r;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= INIT;
      clr_cnt_r   <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      clr_cnt_r   <= clr_cnt_nxt_s;
      init_done_r <= init_done_nxt_s;
    end
  end

  // Sequencer next state: walk every entry once, then freeze the counter in RUN.
  always_comb begin
    state_nxt_s     = state_r;
    clr_cnt_nxt_s   = clr_cnt_r;
    init_done_nxt_s = init_done_r;
    case (state_r)
      INIT: begin
        clr_cnt_nxt_s = clr_cnt_r + CW'(1);
        if (clr_cnt_r == CW'(DEPTH - 1)) begin
          state_nxt_s     = RUN;
          init_done_nxt_s = 1'b1;
        end else begin
          state_nxt_s     = INIT;
          init_done_nxt_s = 1'b0;
        end
      end
      RUN: begin
        state_nxt_s     = RUN;
        init_done_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s     = INIT;
        clr_cnt_nxt_s   = '0;
        init_done_nxt_s = 1'b0;
      end
    endcase
  end

  // Write arbitration: port 1 wins a same-address collision, x0 optionally read-only.
  always_comb begin
    wr0_s = 1'b0;
    wr1_s = 1'b0;
    if (run_s) begin
      wr1_s = bus.we1 && !((ZERO_REG != 0) && (bus.w_addr1 == '0));
      wr0_s = bus.we0 && !((ZERO_REG != 0) && (bus.w_addr0 == '0))
                      && !(bus.we1 && (bus.w_addr0 == bus.w_addr1));
    end else begin
      wr0_s = 1'b0;
      wr1_s = 1'b0;
    end
  end

  // Storage array: sequencer clears during INIT, write ports own it in RUN.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!run_s) begin
        mem_r[clr_cnt_r[ADDR_WIDTH-1:0]] <= '0;
      end else begin
        if (wr0_s) mem_r[bus.w_addr0] <= bus.w_data0;
        if (wr1_s) mem_r[bus.w_addr1] <= bus.w_data1;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
    ) u_rd (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (run_s),
      .r_en    (bus.r_en[i]),
      .r_addr  (bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem_q   (mem_r[bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]]),
      .we0     (bus.we0),
      .w_addr0 (bus.w_addr0),
      .w_data0 (bus.w_data0),
      .we1     (bus.we1),
      .w_addr1 (bus.w_addr1),
      .w_data1 (bus.w_data1),
      .r_data  (rdata_s[i])
    );
  end

  // Pack per-port read registers onto the bus.
  always_comb begin
    bus.r_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      bus.r_data[i*WIDTH +: WIDTH] = rdata_s[i];
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: one DUT with hardwired x0 and one without, driven by identical stimulus.
module tb_reg_file_mp;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  typedef struct {
    int         port;
    logic [W-1:0] da;
    logic [W-1:0] db;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  reg_file_mp_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus_a ();
  reg_file_mp_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_RD(NR)) bus_b ();

  reg_file_mp #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(1)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a.slave));
  reg_file_mp #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_RD(NR), .ZERO_REG(0)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b.slave));

  assign bus_b.we0     = bus_a.we0;
  assign bus_b.w_addr0 = bus_a.w_addr0;
  assign bus_b.w_data0 = bus_a.w_data0;
  assign bus_b.we1     = bus_a.we1;
  assign bus_b.w_addr1 = bus_a.w_addr1;
  assign bus_b.w_data1 = bus_a.w_data1;
  assign bus_b.r_en    = bus_a.r_en;
  assign bus_b.r_addr  = bus_a.r_addr;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic idle();
    bus_a.we0 = 1'b0;
    bus_a.we1 = 1'b0;
    bus_a.r_en = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    if (p == 0) begin
      bus_a.we0 = 1'b1; bus_a.w_addr0 = a; bus_a.w_data0 = d;
    end else begin
      bus_a.we1 = 1'b1; bus_a.w_addr1 = a; bus_a.w_data1 = d;
    end
  endtask

  // Call in ascending port order within a cycle so the queue matches the monitor's pop order.
  task automatic rd(input int p, input logic [AW-1:0] a, input logic [W-1:0] da, input logic [W-1:0] db);
    exp_t e;
    bus_a.r_en[p] = 1'b1;
    bus_a.r_addr[p*AW +: AW] = a;
    e.port = p; e.da = da; e.db = db;
    q.push_back(e);
  endtask

  // Monitor: a read issued at a posedge is compared on the following negedge.
  initial begin
    logic [NR-1:0] en;
    exp_t e;
    forever begin
      @(posedge clk);
      en = bus_a.r_en;
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (en[i]) begin
          if (q.size() == 0) begin
            chk($sformatf("sb_empty_p%0d", i), 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk($sformatf("port_order_p%0d", i), W'(e.port), W'(i));
            chk($sformatf("rd_a_p%0d", i), bus_a.r_data[i*W +: W], e.da);
            chk($sformatf("rd_b_p%0d", i), bus_b.r_data[i*W +: W], e.db);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus_a.w_addr0 = '0; bus_a.w_data0 = '0;
    bus_a.w_addr1 = '0; bus_a.w_data1 = '0;
    bus_a.r_addr = '0;
    rst_n = 1'b0;
    tick();
    tick();
    for (int p = 0; p < NR; p++) chk("rst_rdata", bus_a.r_data[p*W +: W], 32'h0);
    chk("rst_init_done", W'(bus_a.init_done), 32'h0);

    // INIT: writes dropped (also on entries already cleared), reads forced to zero
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (k == 1 || k == 10) wr(0, 5'd5, 32'h0000_DEAD);
      if (k == 20) begin
        wr(0, 5'd0, 32'h0000_DEAD);
        wr(1, 5'd1, 32'h0000_BEEF);
      end
      if (k == 10 || k == 32) begin
        rd(0, 5'd5, 32'h0, 32'h0);
        rd(1, 5'd0, 32'h0, 32'h0);
      end
      tick();
      chk("init_done_a", W'(bus_a.init_done), W'(k == 32));
      chk("init_done_b", W'(bus_b.init_done), W'(k == 32));
    end

    for (int a = 0; a < 32; a += 2) begin
      rd(0, AW'(a), 32'h0, 32'h0);
      rd(1, AW'(a + 1), 32'h0, 32'h0);
      tick();
    end
    tick();

    // Plain write then read
    wr(0, 5'd3, 32'h1234_5678);
    tick();
    rd(0, 5'd3, 32'h1234_5678, 32'h1234_5678);
    tick();

    // Same-cycle bypass, both ports on the same address
    wr(1, 5'd7, 32'hCAFE_F00D);
    rd(0, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    rd(1, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tick();
    rd(0, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tick();

    // Collision: port 1 wins both in the array and on the bypass
    wr(0, 5'd9, 32'h0000_0001);
    wr(1, 5'd9, 32'h0000_0002);
    rd(0, 5'd9, 32'h0000_0002, 32'h0000_0002);
    tick();
    rd(1, 5'd9, 32'h0000_0002, 32'h0000_0002);
    tick();

    // x0: hardwired zero on dut_a, ordinary register on dut_b
    wr(0, 5'd0, 32'hFFFF_FFFF);
    rd(0, 5'd0, 32'h0, 32'hFFFF_FFFF);
    tick();
    rd(1, 5'd0, 32'h0, 32'hFFFF_FFFF);
    tick();

    // Two independent writes in one cycle
    wr(0, 5'd10, 32'h0000_AAAA);
    wr(1, 5'd31, 32'h0000_BBBB);
    tick();
    rd(0, 5'd10, 32'h0000_AAAA, 32'h0000_AAAA);
    rd(1, 5'd31, 32'h0000_BBBB, 32'h0000_BBBB);
    tick();

    // Hold: r_en low keeps r_data across writes and address changes
    rd(0, 5'd3, 32'h1234_5678, 32'h1234_5678);
    rd(1, 5'd7, 32'hCAFE_F00D, 32'hCAFE_F00D);
    tick();
    wr(0, 5'd3, 32'h5555_5555);
    wr(1, 5'd7, 32'h6666_6666);
    bus_a.r_addr = {5'd3, 5'd7};
    tick();
    tick();
    chk("hold_a_p0", bus_a.r_data[0 +: W], 32'h1234_5678);
    chk("hold_a_p1", bus_a.r_data[W +: W], 32'hCAFE_F00D);
    chk("hold_b_p0", bus_b.r_data[0 +: W], 32'h1234_5678);
    chk("hold_b_p1", bus_b.r_data[W +: W], 32'hCAFE_F00D);
    rd(0, 5'd3, 32'h5555_5555, 32'h5555_5555);
    rd(1, 5'd7, 32'h6666_6666, 32'h6666_6666);
    tick();
    tick();

    // Mid-RUN reset: outputs cleared, full clear sequence repeated
    rst_n = 1'b0;
    tick();
    chk("mrst_a_p0", bus_a.r_data[0 +: W], 32'h0);
    chk("mrst_a_p1", bus_a.r_data[W +: W], 32'h0);
    chk("mrst_b_p0", bus_b.r_data[0 +: W], 32'h0);
    chk("mrst_done", W'(bus_a.init_done), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k >= 31) chk("mrst_init_done", W'(bus_a.init_done), W'(k == 32));
    end
    rd(0, 5'd3, 32'h0, 32'h0);
    rd(1, 5'd7, 32'h0, 32'h0);
    tick();
    rd(0, 5'd9, 32'h0, 32'h0);
    rd(1, 5'd0, 32'h0, 32'h0);
    tick();
    tick();
    tick();

    chk("sb_drain", W'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
